// File: rtl/serial_pkg.sv
// Shared frame-timing constants for the SERIAL shifter and its scheduler.
package serial_pkg;

  localparam int unsigned SCNT_W = 5;
  localparam int unsigned BYTE_W = 8;

  localparam logic [SCNT_W-1:0] SCNT_GRANT = 5'd0;
  localparam logic [SCNT_W-1:0] SCNT_LATCH = 5'd3;
  localparam logic [SCNT_W-1:0] SCNT_LAST  = 5'd19;

endpackage

// File: rtl/serial_tx_sched_if.sv
// Byte-request handshake between N_REQ requesters and the serial scheduler.
interface serial_tx_sched_if
  import serial_pkg::*;
#(
  parameter int unsigned N_REQ = 4
);

  logic [N_REQ-1:0]        req_valid;
  logic [BYTE_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);

endinterface

// File: rtl/SERIAL.sv
// 8-bit LSB-first shifter driven by the scheduler's frame counter; cs has no reset.
module SERIAL
  import serial_pkg::*;
(
  input  logic              clk,
  input  logic [SCNT_W-1:0] scnt,
  input  logic [BYTE_W-1:0] data_i,
  input  logic              En,
  output logic              data_o,
  output logic              cs
);

  logic [BYTE_W-2:0] sh_q;
  logic              data_q;
  logic              cs_q;

  // Bit 0 leaves at the latch edge; the rest follow on every odd count up to 17.
  always_ff @(posedge clk) begin
    if (scnt == SCNT_LATCH) begin
      sh_q   <= data_i[BYTE_W-1:1];
      data_q <= data_i[0];
      cs_q   <= En;
    end else if (scnt == SCNT_LAST) begin
      cs_q <= 1'b1;
    end else if (scnt > SCNT_LATCH && scnt < SCNT_LAST && scnt[0]) begin
      data_q <= sh_q[0];
      sh_q   <= sh_q >> 1;
    end
  end

  assign data_o = data_q;
  assign cs     = cs_q;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_idx_o
);

  logic [ID_W-1:0] k;
  logic            found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    k         = ptr_i;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req_i[k]) begin
        found     = 1'b1;
        gnt_o[k]  = 1'b1;
        gnt_idx_o = k;
      end
      k = (k == ID_W'(N_REQ - 1)) ? '0 : k + ID_W'(1);
    end
  end

endmodule

// File: rtl/serial_tx_sched.sv
// Frame scheduler: owns the 20-cycle frame counter and round-robins the serial link among requesters.
module serial_tx_sched
  import serial_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  serial_tx_sched_if.slave  req,
  output logic [SCNT_W-1:0] scnt,
  output logic [BYTE_W-1:0] ser_data,
  output logic              ser_en_n,
  output logic              busy,
  output logic [ID_W-1:0]   grant_id,
  output logic              frame_done
);

  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              en_n_q, en_n_d;
  logic              flush_q, flush_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   win;
  logic [BYTE_W-1:0] win_byte;
  logic              any_req;
  logic              grant;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i     (req.req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (win)
  );

  assign any_req = |req.req_valid;
  assign grant   = (scnt_q == SCNT_GRANT) && !flush_q && any_req;

  // Ready is suppressed in a reset cycle so no requester sees an accept that reset discards.
  assign req.req_ready = (grant && !sys_rst) ? gnt : '0;

  always_comb begin
    win_byte = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) win_byte = win_byte | req.req_data[i*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    scnt_d  = scnt_q;
    data_d  = data_q;
    en_n_d  = en_n_q;
    flush_d = flush_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;

    if (scnt_q == SCNT_LAST) begin
      scnt_d  = '0;
      en_n_d  = 1'b1;
      flush_d = 1'b0;
    end else if (scnt_q == SCNT_GRANT) begin
      if (flush_q || any_req) scnt_d = SCNT_W'(1);
    end else begin
      scnt_d = scnt_q + SCNT_W'(1);
    end

    if (grant) begin
      data_d = win_byte;
      en_n_d = 1'b0;
      gid_d  = win;
      ptr_d  = (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      scnt_q  <= '0;
      data_q  <= '0;
      en_n_q  <= 1'b1;
      flush_q <= 1'b1;
      gid_q   <= '0;
      ptr_q   <= '0;
    end else begin
      scnt_q  <= scnt_d;
      data_q  <= data_d;
      en_n_q  <= en_n_d;
      flush_q <= flush_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign scnt       = scnt_q;
  assign ser_data   = data_q;
  assign ser_en_n   = en_n_q;
  assign grant_id   = gid_q;
  assign busy       = (scnt_q != '0) || flush_q;
  assign frame_done = (scnt_q == SCNT_LAST) && !en_n_q;

endmodule

// File: tb/tb_serial_tx_sched.sv
// Directed bench: scheduler plus SERIAL shifter, checking scheduler outputs and the data_o/cs pins.
module tb_serial_tx_sched;
  import serial_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] scnt;
  logic [7:0] ser_data;
  logic       ser_en_n;
  logic       busy;
  logic [1:0] grant_id;
  logic       frame_done;
  logic       pin_data;
  logic       pin_cs;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  serial_tx_sched_if #(.N_REQ(4)) bus ();

  serial_tx_sched #(
    .N_REQ (4),
    .ID_W  (2)
  ) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .req        (bus),
    .scnt       (scnt),
    .ser_data   (ser_data),
    .ser_en_n   (ser_en_n),
    .busy       (busy),
    .grant_id   (grant_id),
    .frame_done (frame_done)
  );

  SERIAL u_ser (
    .clk    (clk),
    .scnt   (scnt),
    .data_i (ser_data),
    .En     (ser_en_n),
    .data_o (pin_data),
    .cs     (pin_cs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Entered at a scnt=0 cycle with the winner's valid raised; leaves at the next scnt=0 cycle.
  task automatic run_frame(input int unsigned id, input logic [7:0] bv, input bit glitch);
    #1;
    chk("grant_scnt", 32'(scnt), 0);
    chk("grant_ready", 32'(bus.req_ready), 32'(1) << id);
    @(negedge clk);
    bus.req_valid[2'(id)] = 1'b0;
    for (int unsigned s = 1; s <= 19; s++) begin
      if (s > 1) @(negedge clk);
      if (glitch && s == 5)  bus.req_valid[2'(id + 1)] = 1'b1;
      if (glitch && s == 12) bus.req_valid[2'(id + 1)] = 1'b0;
      #1;
      chk("frm_scnt",  32'(scnt), s);
      chk("frm_en_n",  32'(ser_en_n), 0);
      chk("frm_gid",   32'(grant_id), id);
      chk("frm_data",  32'(ser_data), 32'(bv));
      chk("frm_ready", 32'(bus.req_ready), 0);
      chk("frm_busy",  32'(busy), 1);
      chk("frm_done",  32'(frame_done), (s == 19) ? 1 : 0);
      chk("frm_cs",    32'(pin_cs), (s < 4) ? 1 : 0);
      if (s >= 4) chk("frm_pin", 32'(pin_data), 32'(bv[3'((s - 4) / 2)]));
    end
    @(negedge clk);
    #1;
    chk("end_scnt", 32'(scnt), 0);
    chk("end_en_n", 32'(ser_en_n), 1);
    chk("end_cs",   32'(pin_cs), 1);
    chk("end_done", 32'(frame_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    // 1: reset, then flush frame with no grant, then park
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_scnt",  32'(scnt), 0);
    chk("rst_en_n",  32'(ser_en_n), 1);
    chk("rst_gid",   32'(grant_id), 0);
    chk("rst_data",  32'(ser_data), 0);
    chk("rst_done",  32'(frame_done), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_busy",  32'(busy), 1);
    rst = 1'b0;
    for (int unsigned s = 1; s <= 19; s++) begin
      @(negedge clk);
      #1;
      chk("fl_scnt", 32'(scnt), s);
      chk("fl_en_n", 32'(ser_en_n), 1);
      chk("fl_busy", 32'(busy), 1);
      chk("fl_done", 32'(frame_done), 0);
      if (s >= 4) chk("fl_cs", 32'(pin_cs), 1);
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("park_scnt", 32'(scnt), 0);
      chk("park_busy", 32'(busy), 0);
      chk("park_cs",   32'(pin_cs), 1);
    end

    // 2: single request 0xA5 from requester 0
    bus.req_data  = 32'h0000_00A5;
    bus.req_valid = 4'b0001;
    run_frame(0, 8'hA5, 1'b0);

    // 3: reset the pointer, then four held requests in consecutive frames
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst3_scnt", 32'(scnt), 0);
    chk("rst3_busy", 32'(busy), 1);
    rst           = 1'b0;
    bus.req_data  = 32'h4433_2211;
    bus.req_valid = 4'b1111;
    for (int unsigned s = 1; s <= 19; s++) begin
      @(negedge clk);
      #1;
      chk("fl3_scnt",  32'(scnt), s);
      chk("fl3_ready", 32'(bus.req_ready), 0);
      chk("fl3_en_n",  32'(ser_en_n), 1);
    end
    @(negedge clk);
    run_frame(0, 8'h11, 1'b0);
    run_frame(1, 8'h22, 1'b0);
    run_frame(2, 8'h33, 1'b0);
    run_frame(3, 8'h44, 1'b0);

    // 4: requester 2 re-asserts after each accept while requester 0 stays pending
    bus.req_data  = 32'h0081_0000;
    bus.req_valid = 4'b0100;
    run_frame(2, 8'h81, 1'b0);
    bus.req_data  = 32'h00C3_003C;
    bus.req_valid = 4'b0101;
    run_frame(0, 8'h3C, 1'b0);
    bus.req_data  = 32'h00C3_00F0;
    bus.req_valid = 4'b0101;
    run_frame(2, 8'hC3, 1'b0);
    bus.req_data  = 32'h005A_00F0;
    bus.req_valid = 4'b0101;
    run_frame(0, 8'hF0, 1'b0);

    // 6: requester 3 pulses valid mid-frame only; no grant, counter parks afterwards
    run_frame(2, 8'h5A, 1'b1);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("g_scnt",  32'(scnt), 0);
      chk("g_busy",  32'(busy), 0);
      chk("g_ready", 32'(bus.req_ready), 0);
      chk("g_en_n",  32'(ser_en_n), 1);
    end

    // 5: reset at scnt=9 of a granted frame; pending request waits for the flush
    bus.req_data  = 32'h6E00_0000;
    bus.req_valid = 4'b1000;
    #1;
    chk("r5_ready", 32'(bus.req_ready), 32'h8);
    for (int unsigned s = 1; s <= 9; s++) begin
      @(negedge clk);
      if (s == 1) bus.req_valid = 4'b0000;
      if (s == 5) begin
        bus.req_data  = 32'h6E00_7700;
        bus.req_valid = 4'b0010;
      end
      #1;
      chk("r5_scnt", 32'(scnt), s);
      chk("r5_en_n", 32'(ser_en_n), 0);
      chk("r5_gid",  32'(grant_id), 3);
      if (s >= 4) chk("r5_cs", 32'(pin_cs), 0);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("r5r_scnt",  32'(scnt), 0);
    chk("r5r_en_n",  32'(ser_en_n), 1);
    chk("r5r_busy",  32'(busy), 1);
    chk("r5r_done",  32'(frame_done), 0);
    chk("r5r_cs",    32'(pin_cs), 0);
    rst = 1'b0;
    #1;
    chk("r5r_ready", 32'(bus.req_ready), 0);
    for (int unsigned s = 1; s <= 19; s++) begin
      @(negedge clk);
      #1;
      chk("fl5_scnt",  32'(scnt), s);
      chk("fl5_en_n",  32'(ser_en_n), 1);
      chk("fl5_ready", 32'(bus.req_ready), 0);
      chk("fl5_cs",    32'(pin_cs), (s < 4) ? 0 : 1);
    end
    @(negedge clk);
    run_frame(1, 8'h77, 1'b0);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("fin_scnt", 32'(scnt), 0);
      chk("fin_busy", 32'(busy), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
